// File: rtl/fib_ram_writer.sv
// Fibonacci table writer: fills an internal RAM with F(0)..F(DEPTH-1), mirrors each write on wr_*.
// Build option: define FIB_SAT_EN to saturate overflowing terms at 2**DW-1 instead of wrapping.
module fib_ram_writer #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          valid,
    output logic          ovf,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned   MEM_WORDS = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [DW-1:0] MAX_VAL   = {DW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] cur_q, cur_d;
    logic [DW-1:0] nxt_q, nxt_d;
    logic          cur_ov_q, cur_ov_d;
    logic          nxt_ov_q, nxt_ov_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [DW:0]   sum_c;

    logic [DW-1:0] mem [MEM_WORDS];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign sum_c = {1'b0, cur_q} + {1'b0, nxt_q};

    // Datapath and output next values; outputs are loaded from the upcoming state
    always_comb begin
        idx_d     = idx_q;
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        cur_ov_d  = cur_ov_q;
        nxt_ov_d  = nxt_ov_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = (state_d == S_FILL);
        done_d    = (state_d == S_DONE);
        wr_en_d   = (state_d == S_FILL);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d    = '0;
                    cur_d    = '0;
                    nxt_d    = DW'(1);
                    cur_ov_d = 1'b0;
                    nxt_ov_d = 1'b0;
                    valid_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            S_FILL: begin
                idx_d    = idx_q + AW'(1);
                cur_d    = nxt_q;
                cur_ov_d = nxt_ov_q;
                nxt_ov_d = sum_c[DW];
`ifdef FIB_SAT_EN
                nxt_d    = sum_c[DW] ? MAX_VAL : sum_c[DW-1:0];
`else
                nxt_d    = sum_c[DW-1:0];
`endif
            end
            default: ;
        endcase

        if (state_d == S_DONE) valid_d = 1'b1;

        // The carry tag only counts once its term is actually written
        if (state_d == S_FILL) begin
            wr_addr_d = idx_d;
            wr_data_d = cur_d;
            ovf_d     = ovf_d | cur_ov_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            cur_q     <= '0;
            nxt_q     <= DW'(1);
            cur_ov_q  <= 1'b0;
            nxt_ov_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            cur_ov_q  <= cur_ov_d;
            nxt_ov_q  <= nxt_ov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // RAM is driven by the registered write bus, so it matches wr_* exactly
    always_ff @(posedge clk) begin
        if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end

    assign rd_data = mem[rd_addr];
    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;
    assign ovf     = ovf_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
